// File: rtl/game_sequencer.sv
// Game flow controller for the typing game: SELECT -> COUNTDOWN -> INGAME -> FINISH.
// Optional pause support is compiled in when GAME_SEQ_PAUSE_EN is defined.
module game_sequencer #(
   parameter int TICKS_PER_SEC  = 10,
   parameter int MAX_GAME_TICKS = 1800,
   parameter int MAX_VALUE      = 120,
   parameter int DEFAULT_VALUE  = 30
) (
   input  logic        clk_div,
   input  logic        rst,
   input  logic        start_key,
   input  logic        esc_key,
   input  logic        pause_key,
   input  logic        mode_sel,
   input  logic [6:0]  value_sel,
   input  logic        finish_in,
   output logic [1:0]  state,
   output logic        mode_lat,
   output logic [6:0]  value_lat,
   output logic [1:0]  cd_digit,
   output logic [10:0] elapsed,
   output logic        timeout,
   output logic        paused
);

   localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [10:0]       ELAPSED_LAST = 11'(MAX_GAME_TICKS - 1);
   localparam logic [10:0]       ELAPSED_MAX  = 11'(MAX_GAME_TICKS);
   localparam logic [6:0]        VALUE_MAX    = 7'(MAX_VALUE);
   localparam logic [6:0]        VALUE_RESET  = 7'(DEFAULT_VALUE);

   typedef enum logic [1:0] {
      SELECT    = 2'd0,
      COUNTDOWN = 2'd1,
      INGAME    = 2'd2,
      FINISH    = 2'd3
   } gameState_t;

   gameState_t        state_q, state_d;
   logic              mode_q, mode_d;
   logic [6:0]        value_q, value_d;
   logic [1:0]        cd_q, cd_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [10:0]       elapsed_q, elapsed_d;
   logic              timeout_q, timeout_d;
   logic              startDly_q, escDly_q;
   logic              startRise, escRise;
   logic [6:0]        valueClamped;

   assign startRise = start_key & ~startDly_q;
   assign escRise   = esc_key & ~escDly_q;

   always_comb begin
      valueClamped = value_sel;
      if (value_sel == 7'd0)
         valueClamped = 7'd1;
      else if (value_sel > VALUE_MAX)
         valueClamped = VALUE_MAX;
   end

`ifdef GAME_SEQ_PAUSE_EN
   logic paused_q, paused_d;
   logic pauseDly_q;
   logic pauseRise;

   assign pauseRise = pause_key & ~pauseDly_q;

   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         paused_q   <= 1'b0;
         pauseDly_q <= 1'b0;
      end else begin
         paused_q   <= paused_d;
         pauseDly_q <= pause_key;
      end
   end
`else
   logic paused_q;
   logic unusedPause;

   assign paused_q    = 1'b0;
   assign unusedPause = pause_key;
`endif

   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         state_q    <= SELECT;
         mode_q     <= 1'b0;
         value_q    <= VALUE_RESET;
         cd_q       <= 2'd0;
         tick_q     <= '0;
         elapsed_q  <= 11'd0;
         timeout_q  <= 1'b0;
         startDly_q <= 1'b0;
         escDly_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         value_q    <= value_d;
         cd_q       <= cd_d;
         tick_q     <= tick_d;
         elapsed_q  <= elapsed_d;
         timeout_q  <= timeout_d;
         startDly_q <= start_key;
         escDly_q   <= esc_key;
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      value_d   = value_q;
      cd_d      = cd_q;
      tick_d    = tick_q;
      elapsed_d = elapsed_q;
      timeout_d = timeout_q;
`ifdef GAME_SEQ_PAUSE_EN
      paused_d  = paused_q;
`endif

      case (state_q)
         SELECT: begin
            if (!escRise && startRise) begin
               state_d   = COUNTDOWN;
               mode_d    = mode_sel;
               value_d   = valueClamped;
               cd_d      = 2'd3;
               tick_d    = '0;
               elapsed_d = 11'd0;
               timeout_d = 1'b0;
            end
         end

         COUNTDOWN: begin
            if (escRise) begin
               state_d = SELECT;
               cd_d    = 2'd0;
            end else if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (cd_q == 2'd1) begin
                  state_d = INGAME;
                  cd_d    = 2'd0;
               end else begin
                  cd_d = cd_q - 2'd1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end

         // While paused only esc and a second pause press are honoured
         INGAME: begin
            if (escRise) begin
               state_d = SELECT;
            end
`ifdef GAME_SEQ_PAUSE_EN
            else if (paused_q) begin
               if (pauseRise)
                  paused_d = 1'b0;
            end
`endif
            else if (finish_in) begin
               state_d = FINISH;
            end else if (elapsed_q == ELAPSED_LAST) begin
               state_d   = FINISH;
               elapsed_d = ELAPSED_MAX;
               timeout_d = 1'b1;
            end
`ifdef GAME_SEQ_PAUSE_EN
            else if (pauseRise) begin
               paused_d = 1'b1;
            end
`endif
            else begin
               elapsed_d = elapsed_q + 11'd1;
            end
         end

         FINISH: begin
            if (startRise || escRise)
               state_d = SELECT;
         end

         default: state_d = SELECT;
      endcase

      // elapsed is left alone on return to SELECT so the last result stays visible
      if (state_d == SELECT) begin
         timeout_d = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
         paused_d  = 1'b0;
`endif
      end
   end

   assign state     = paused_q ? COUNTDOWN : state_q;
   assign mode_lat  = mode_q;
   assign value_lat = value_q;
   assign cd_digit  = cd_q;
   assign elapsed   = elapsed_q;
   assign timeout   = timeout_q;
   assign paused    = paused_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a behavioural game model predicts each cycle,
// a monitor compares every registered output one cycle later.
module tb_game_sequencer;

   localparam int T_SEC    = 10;
   localparam int MAX_G    = 1800;
   localparam int MAX_V    = 120;
   localparam int DEF_V    = 30;
`ifdef GAME_SEQ_PAUSE_EN
   localparam bit PAUSE_ON = 1'b1;
`else
   localparam bit PAUSE_ON = 1'b0;
`endif

   logic        clk_div = 1'b0;
   logic        rst;
   logic        start_key, esc_key, pause_key, mode_sel, finish_in;
   logic [6:0]  value_sel;
   logic [1:0]  state;
   logic        mode_lat;
   logic [6:0]  value_lat;
   logic [1:0]  cd_digit;
   logic [10:0] elapsed;
   logic        timeout;
   logic        paused;

   game_sequencer #(
      .TICKS_PER_SEC (T_SEC),
      .MAX_GAME_TICKS(MAX_G),
      .MAX_VALUE     (MAX_V),
      .DEFAULT_VALUE (DEF_V)
   ) dut (
      .clk_div  (clk_div),
      .rst      (rst),
      .start_key(start_key),
      .esc_key  (esc_key),
      .pause_key(pause_key),
      .mode_sel (mode_sel),
      .value_sel(value_sel),
      .finish_in(finish_in),
      .state    (state),
      .mode_lat (mode_lat),
      .value_lat(value_lat),
      .cd_digit (cd_digit),
      .elapsed  (elapsed),
      .timeout  (timeout),
      .paused   (paused)
   );

   always #5 clk_div = ~clk_div;

   typedef struct {
      int st;
      int mode;
      int value;
      int cd;
      int elapsed;
      int timeout;
      int paused;
   } expect_t;

   expect_t sbQueue[$];
   int checksTotal  = 0;
   int checksPassed = 0;

   // Behavioural game model: countdown tracked as cycles since entry
   int mState, mMode, mValue, mCdCount, mElapsed, mTimeout, mPaused;
   int mPrevStart, mPrevEsc, mPrevPause;

   task automatic modelReset();
      mState = 0; mMode = 0; mValue = DEF_V; mCdCount = 0;
      mElapsed = 0; mTimeout = 0; mPaused = 0;
      mPrevStart = 0; mPrevEsc = 0; mPrevPause = 0;
   endtask

   function automatic int clampValue(int v);
      if (v == 0) return 1;
      if (v > MAX_V) return MAX_V;
      return v;
   endfunction

   task automatic modelStep(int s, int e, int p, int f, int m, int v);
      int sR, eR, pR;
      sR = s & ~mPrevStart & 1;
      eR = e & ~mPrevEsc & 1;
      pR = p & ~mPrevPause & 1;
      mPrevStart = s; mPrevEsc = e; mPrevPause = p;
      case (mState)
         0: if (!eR && sR) begin
               mState = 1; mMode = m; mValue = clampValue(v);
               mCdCount = 0; mElapsed = 0; mTimeout = 0;
            end
         1: if (eR) mState = 0;
            else begin
               mCdCount++;
               if (mCdCount == 3 * T_SEC) mState = 2;
            end
         2: if (eR) mState = 0;
            else if (mPaused != 0) begin
               if (pR) mPaused = 0;
            end
            else if (f) mState = 3;
            else if (mElapsed == MAX_G - 1) begin
               mElapsed = MAX_G; mTimeout = 1; mState = 3;
            end
            else if (PAUSE_ON && pR) mPaused = 1;
            else mElapsed++;
         default: if (sR || eR) mState = 0;
      endcase
      if (mState == 0) begin
         mTimeout = 0; mPaused = 0;
      end
   endtask

   task automatic checkOutput(string name, int actual, int expected);
      checksTotal++;
      if (actual == expected) checksPassed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
   endtask

   // One cycle: drive at the falling edge, predict the post-edge outputs
   task automatic applyStimulus(int s, int e, int p, int f, int m, int v);
      expect_t x;
      start_key = s[0]; esc_key = e[0]; pause_key = p[0];
      finish_in = f[0]; mode_sel = m[0]; value_sel = v[6:0];
      modelStep(s, e, p, f, m, v);
      x.st      = (mPaused != 0) ? 1 : mState;
      x.mode    = mMode;
      x.value   = mValue;
      x.cd      = (mState == 1) ? 3 - mCdCount / T_SEC : 0;
      x.elapsed = mElapsed;
      x.timeout = mTimeout;
      x.paused  = mPaused;
      sbQueue.push_back(x);
      @(negedge clk_div);
   endtask

   task automatic checkResetValues(string tag);
      checkOutput({tag, "_state"},   int'(state),     0);
      checkOutput({tag, "_mode"},    int'(mode_lat),  0);
      checkOutput({tag, "_value"},   int'(value_lat), DEF_V);
      checkOutput({tag, "_cd"},      int'(cd_digit),  0);
      checkOutput({tag, "_elapsed"}, int'(elapsed),   0);
      checkOutput({tag, "_timeout"}, int'(timeout),   0);
      checkOutput({tag, "_paused"},  int'(paused),    0);
   endtask

   // Monitor: every clock after reset the DUT outputs are a fresh response
   initial begin
      expect_t x;
      forever begin
         @(posedge clk_div);
         #1;
         if (!rst && sbQueue.size() > 0) begin
            x = sbQueue.pop_front();
            checkOutput("state",   int'(state),     x.st);
            checkOutput("mode",    int'(mode_lat),  x.mode);
            checkOutput("value",   int'(value_lat), x.value);
            checkOutput("cd",      int'(cd_digit),  x.cd);
            checkOutput("elapsed", int'(elapsed),   x.elapsed);
            checkOutput("timeout", int'(timeout),   x.timeout);
            checkOutput("paused",  int'(paused),    x.paused);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s, e, p, f, m, v;
      rst = 1'b1;
      start_key = 1'b0; esc_key = 1'b0; pause_key = 1'b0;
      finish_in = 1'b0; mode_sel = 1'b0; value_sel = 7'd0;
      modelReset();
      repeat (3) @(negedge clk_div);
      checkResetValues("reset");
      rst = 1'b0;

      $display("[TB] game 1: value 0 clamps to 1, finish after 57 ticks");
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3 * T_SEC; i++) applyStimulus(0, 0, 0, 0, i & 1, $urandom_range(0, 127));
      for (int i = 0; i < 57; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] game 2: value 127 clamps to 120, guard limit reached");
      applyStimulus(1, 0, 0, 0, 0, 127);
      for (int i = 0; i < 3 * T_SEC + MAX_G + 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] game 3: start held through the whole game");
      for (int i = 0; i < 3 * T_SEC + 20; i++) applyStimulus(1, 0, 0, 0, 1, 64);
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 1, 1, 64);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] game 4: esc during digit 2");
      applyStimulus(1, 0, 0, 0, 0, 45);
      for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] randomized play");
      s = 0; e = 0; p = 0;
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 15) == 0) s = 1 - s;
         if ($urandom_range(0, 39) == 0) e = 1 - e;
         if ($urandom_range(0, 19) == 0) p = 1 - p;
         f = ($urandom_range(0, 59) == 0) ? 1 : 0;
         m = $urandom_range(0, 1);
         v = $urandom_range(0, 127);
         if (i == 2500) begin
            rst = 1'b1;
            #1;
            checkResetValues("midreset");
            modelReset();
            @(negedge clk_div);
            rst = 1'b0;
         end
         applyStimulus(s, e, p, f, m, v);
      end

      for (int i = 0; i < 10 && sbQueue.size() > 0; i++) @(negedge clk_div);
      if (sbQueue.size() > 0) begin
         checksTotal++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", sbQueue.size());
      end
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
